automat_arbiter: RTL

AUTOMAT_ARBITER -- requirements
Module: automat_arbiter

---
 rtl/automat_arbiter_if.sv | 23 ++
 rtl/automat_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/automat_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared start/stop automaton.
interface automat_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             err;
  logic             auto_start;
  logic             auto_stop;
  logic             auto_status;
  logic             auto_clear;

  modport master (
    output req, auto_status, auto_clear,
    input  gnt, done, err, auto_start, auto_stop
  );

  modport slave (
    input  req, auto_status, auto_clear,
    output gnt, done, err, auto_start, auto_stop
  );
endinterface

// File: rtl/automat_arbiter.sv
// Round-robin arbiter sharing one start/stop automaton among N_REQ requesters, one job at a time.
// Define AUTOMAT_ARB_TIMEOUT_EN to add the WAIT_RUN/WAIT_CLR watchdog and the err pulse.
module automat_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TMO_CYC = 64
) (
  input logic              clk,
  input logic              rst_n,
  automat_arbiter_if.slave bus
);
  localparam int                PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0]  ONE  = N_REQ'(1);
  localparam logic [PW-1:0]     LAST = PW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_RUN, STOP, WAIT_CLR, FINISH
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic             auto_start_q, auto_stop_q;
  logic [PW-1:0]    ptr, winner, pick;
  logic             run_exit, clr_exit;

  // Scan downwards from the farthest offset so the nearest request at/above ptr wins last.
  always_comb begin
    logic [PW-1:0] cand;
    cand = '0;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N_REQ);
      if (bus.req[cand]) pick = cand;
    end
  end

`ifdef AUTOMAT_ARB_TIMEOUT_EN
  logic [7:0] wd;
  logic       wd_hit, tmo_seen, err_q;

  // Firing when the next count would reach TMO_CYC puts the exit TMO_CYC cycles after entry.
  assign wd_hit   = (wd + 8'd1) == 8'(TMO_CYC);
  assign run_exit = bus.auto_status | wd_hit;
  assign clr_exit = bus.auto_clear  | wd_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd       <= '0;
      tmo_seen <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == START || state == STOP)
        wd <= '0;
      else if (state == WAIT_RUN || state == WAIT_CLR)
        wd <= wd + 8'd1;
      if (state == IDLE)
        tmo_seen <= 1'b0;
      else if (state == WAIT_RUN && !bus.auto_status && wd_hit)
        tmo_seen <= 1'b1;
      if (state == WAIT_CLR && clr_exit)
        err_q <= tmo_seen | !bus.auto_clear;
    end
  end

  assign bus.err = err_q;
`else
  assign run_exit = bus.auto_status;
  assign clr_exit = bus.auto_clear;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      auto_start_q <= 1'b0;
      auto_stop_q  <= 1'b0;
      ptr          <= '0;
      winner       <= '0;
    end else begin
      auto_start_q <= 1'b0;
      auto_stop_q  <= 1'b0;
      done_q       <= '0;
      unique case (state)
        IDLE: begin
          // A busy or not-yet-cleared automaton blocks arbitration entirely.
          if (|bus.req && !bus.auto_status && !bus.auto_clear) begin
            winner       <= pick;
            gnt_q        <= ONE << pick;
            auto_start_q <= 1'b1;
            state        <= START;
          end
        end
        START:    state <= WAIT_RUN;
        WAIT_RUN: begin
          if (run_exit) begin
            auto_stop_q <= 1'b1;
            state       <= STOP;
          end
        end
        STOP:     state <= WAIT_CLR;
        WAIT_CLR: begin
          if (clr_exit) begin
            done_q <= ONE << winner;
            gnt_q  <= '0;
            ptr    <= (winner == LAST) ? '0 : winner + PW'(1);
            state  <= FINISH;
          end
        end
        FINISH:   state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.auto_start = auto_start_q;
  assign bus.auto_stop  = auto_stop_q;
endmodule
